dpu_cmd_arbiter: RTL and testbench

//  Shares the single dpu_top PIO command port between NREQ requesters (host AXI4-Lite bridge, weight/fmap DMA loader, debug).

---
 rtl/dpu_pkg.sv | 27 ++
 rtl/dpu_rr_arb.sv | 32 +++
 rtl/dpu_cmd_arbiter.sv | 143 ++++++++++++++
 tb/tb_dpu_cmd_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpu_pkg.sv
// Shared types and defaults for the dpu_top command arbiter.
package dpu_pkg;

    typedef enum logic [2:0] {
        CMD_NOP        = 3'd0,
        CMD_WRITE_BYTE = 3'd1,
        CMD_RUN        = 3'd2,
        CMD_SET_ADDR   = 3'd3,
        CMD_READ_BYTE  = 3'd4
    } cmd_type_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP,
        S_WAIT_RUN,
        S_DONE
    } arb_state_t;

    localparam logic [7:0] DEF_RSP_MASK = 8'h10;
    localparam logic [7:0] DEF_RUN_MASK = 8'h04;

    function automatic logic mask_hit(input logic [7:0] mask, input logic [2:0] cmd_type);
        return mask[cmd_type];
    endfunction

endpackage

// File: rtl/dpu_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module dpu_rr_arb #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int cand;

    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!any && req[cand]) begin
                any       = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
        if (any) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/dpu_cmd_arbiter.sv
// Shares the single dpu_top PIO command port between NREQ requesters,
// one command in flight, response routed back to the grant owner.
module dpu_cmd_arbiter
    import dpu_pkg::*;
#(
    parameter int         NREQ      = 2,
    parameter int         ADDR_BITS = 24,
    parameter logic [7:0] RSP_MASK  = DEF_RSP_MASK,
    parameter logic [7:0] RUN_MASK  = DEF_RUN_MASK,
    parameter int         TIMEOUT   = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*3-1:0]         req_type,
    input  logic [NREQ*ADDR_BITS-1:0] req_addr,
    input  logic [NREQ*8-1:0]         req_data,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [7:0]                rsp_data,
    output logic                      rsp_err,
    output logic                      dpu_cmd_valid,
    input  logic                      dpu_cmd_ready,
    output logic [2:0]                dpu_cmd_type,
    output logic [ADDR_BITS-1:0]      dpu_cmd_addr,
    output logic [7:0]                dpu_cmd_data,
    input  logic                      dpu_rsp_valid,
    input  logic [7:0]                dpu_rsp_data,
    input  logic                      dpu_done,
    input  logic                      dpu_reload_req,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy_arb
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    arb_state_t           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     owner_q;
    logic [CNT_W-1:0]     wait_cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic                 timeout_hit;
    logic [2:0]           type_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [7:0]           data_q;
    logic [7:0]           rsp_q;
    logic                 err_q;

    logic [NREQ-1:0]      grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_any;

    dpu_rr_arb #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign req_ready = (state == S_IDLE) ? grant : '0;

    // The forced release lands on the same edge the counter reaches TIMEOUT-1.
    assign cnt_next    = wait_cnt + 1'b1;
    assign timeout_hit = (cnt_next == CNT_W'(TIMEOUT - 1));

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            owner_q  <= '0;
            wait_cnt <= '0;
            type_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rsp_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        owner_q <= grant_idx;
                        type_q  <= req_type[3*grant_idx +: 3];
                        addr_q  <= req_addr[ADDR_BITS*grant_idx +: ADDR_BITS];
                        data_q  <= req_data[8*grant_idx +: 8];
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (dpu_cmd_ready) begin
                        wait_cnt <= '0;
                        rsp_q    <= '0;
                        err_q    <= 1'b0;
                        if (mask_hit(RSP_MASK, type_q))      state <= S_WAIT_RSP;
                        else if (mask_hit(RUN_MASK, type_q)) state <= S_WAIT_RUN;
                        else                                 state <= S_DONE;
                    end
                end
                S_WAIT_RSP: begin
                    wait_cnt <= cnt_next;
                    if (dpu_rsp_valid) begin
                        rsp_q <= dpu_rsp_data;
                        state <= S_DONE;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_WAIT_RUN: begin
                    wait_cnt <= cnt_next;
                    if (dpu_done || dpu_reload_req) begin
                        state <= S_DONE;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    rr_ptr <= (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == S_DONE) rsp_valid[owner_q] = 1'b1;
    end

    assign rsp_data      = (state == S_DONE) ? rsp_q : 8'h00;
    assign rsp_err       = (state == S_DONE) && err_q;
    assign dpu_cmd_valid = (state == S_ISSUE);
    assign dpu_cmd_type  = type_q;
    assign dpu_cmd_addr  = addr_q;
    assign dpu_cmd_data  = data_q;
    assign owner         = owner_q;
    assign busy_arb      = (state != S_IDLE);

endmodule

// File: tb/tb_dpu_cmd_arbiter.sv
// Directed bench for dpu_cmd_arbiter; a second instance with TIMEOUT=16 covers the timeout paths.
module tb_dpu_cmd_arbiter;
    import dpu_pkg::*;

    localparam int NREQ = 2;
    localparam int AB   = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      t_req_valid = '0;
    logic [NREQ*3-1:0]    req_type = '0;
    logic [NREQ*AB-1:0]   req_addr = '0;
    logic [NREQ*8-1:0]    req_data = '0;
    logic                 dpu_cmd_ready = 1'b0;
    logic                 t_dpu_cmd_ready = 1'b0;
    logic                 dpu_rsp_valid = 1'b0;
    logic [7:0]           dpu_rsp_data = '0;
    logic                 dpu_done = 1'b0;
    logic                 dpu_reload_req = 1'b0;

    logic [NREQ-1:0] req_ready, rsp_valid, t_req_ready, t_rsp_valid;
    logic [7:0]      rsp_data, dpu_cmd_data, t_rsp_data, t_dpu_cmd_data;
    logic            rsp_err, dpu_cmd_valid, busy_arb, t_rsp_err, t_dpu_cmd_valid, t_busy_arb;
    logic [2:0]      dpu_cmd_type, t_dpu_cmd_type;
    logic [AB-1:0]   dpu_cmd_addr, t_dpu_cmd_addr;
    logic [0:0]      owner, t_owner;

    int total = 0;
    int bad   = 0;

    dpu_cmd_arbiter #(.NREQ(NREQ), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .dpu_cmd_valid(dpu_cmd_valid), .dpu_cmd_ready(dpu_cmd_ready),
        .dpu_cmd_type(dpu_cmd_type), .dpu_cmd_addr(dpu_cmd_addr), .dpu_cmd_data(dpu_cmd_data),
        .dpu_rsp_valid(dpu_rsp_valid), .dpu_rsp_data(dpu_rsp_data),
        .dpu_done(dpu_done), .dpu_reload_req(dpu_reload_req),
        .owner(owner), .busy_arb(busy_arb)
    );

    dpu_cmd_arbiter #(.NREQ(NREQ), .ADDR_BITS(AB), .TIMEOUT(16)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .req_valid(t_req_valid), .req_ready(t_req_ready),
        .req_type(req_type), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(t_rsp_valid), .rsp_data(t_rsp_data), .rsp_err(t_rsp_err),
        .dpu_cmd_valid(t_dpu_cmd_valid), .dpu_cmd_ready(t_dpu_cmd_ready),
        .dpu_cmd_type(t_dpu_cmd_type), .dpu_cmd_addr(t_dpu_cmd_addr), .dpu_cmd_data(t_dpu_cmd_data),
        .dpu_rsp_valid(dpu_rsp_valid), .dpu_rsp_data(dpu_rsp_data),
        .dpu_done(dpu_done), .dpu_reload_req(dpu_reload_req),
        .owner(t_owner), .busy_arb(t_busy_arb)
    );

    // Inputs change 1 ns after the rising edge; checks follow once combinational paths settle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_data, rsp_err, dpu_cmd_valid, dpu_cmd_type,
             dpu_cmd_addr, dpu_cmd_data, owner, busy_arb} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h err=%b cv=%b own=%b busy=%b, want all 0",
                     req_ready, rsp_valid, rsp_data, rsp_err, dpu_cmd_valid, owner, busy_arb);
        end
        rst_n = 1'b1;
        next_cycle();
        total++;
        if (busy_arb !== 1'b0 || t_busy_arb !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle: busy=%b t_busy=%b, want 0 0", busy_arb, t_busy_arb);
        end
    endtask

    task automatic test_write_byte();
        req_valid = 2'b01;
        req_type[2:0] = CMD_WRITE_BYTE;
        req_addr[AB-1:0] = 24'h000123;
        req_data[7:0] = 8'hA5;
        dpu_cmd_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL write_ready: got %b want 01", req_ready);
        end
        next_cycle();
        req_valid = 2'b00;
        #1;
        total++;
        if (dpu_cmd_valid !== 1'b1 || dpu_cmd_type !== 3'd1 || dpu_cmd_addr !== 24'h000123 ||
            dpu_cmd_data !== 8'hA5 || owner !== 1'b0 || busy_arb !== 1'b1) begin
            bad++;
            $display("FAIL write_cmd: got v=%b t=%0d a=%h d=%h own=%b busy=%b want 1 1 000123 a5 0 1",
                     dpu_cmd_valid, dpu_cmd_type, dpu_cmd_addr, dpu_cmd_data, owner, busy_arb);
        end
        next_cycle();
        total++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_data !== 8'h00 || dpu_cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL write_rsp: got rv=%b err=%b rd=%h cv=%b want 01 0 00 0",
                     rsp_valid, rsp_err, rsp_data, dpu_cmd_valid);
        end
        next_cycle();
        total++;
        if (rsp_valid !== 2'b00 || busy_arb !== 1'b0) begin
            bad++;
            $display("FAIL write_rsp_one_cycle: got rv=%b busy=%b want 00 0", rsp_valid, busy_arb);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] g [4];
        logic [1:0] exp_g [4];
        int n = 0;
        int overlap = 0;
        int drained = 0;
        exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
        req_valid = 2'b11;
        req_type = {CMD_WRITE_BYTE, CMD_WRITE_BYTE};
        for (int c = 0; c < 40 && n < 4; c++) begin
            #1;
            if (dpu_cmd_valid && req_ready != 2'b00) overlap++;
            if (req_ready != 2'b00) begin
                g[n] = req_ready;
                n++;
            end
            next_cycle();
        end
        req_valid = 2'b00;
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL rr_grant_count: got %0d grants want 4", n);
        end
        for (int k = 0; k < n; k++) begin
            total++;
            if (g[k] !== exp_g[k]) begin
                bad++;
                $display("FAIL rr_grant_%0d: got %b want %b", k, g[k], exp_g[k]);
            end
        end
        total++;
        if (overlap != 0) begin
            bad++;
            $display("FAIL rr_overlap: got %0d grants during dpu_cmd_valid want 0", overlap);
        end
        for (int c = 0; c < 10 && busy_arb; c++) next_cycle();
        drained = busy_arb ? 0 : 1;
        total++;
        if (drained != 1) begin
            bad++;
            $display("FAIL rr_drain: busy_arb still %b want 0", busy_arb);
        end
    endtask

    task automatic test_read_byte();
        int early = 0;
        req_valid = 2'b10;
        req_type[5:3] = CMD_READ_BYTE;
        req_addr[2*AB-1:AB] = 24'h00ABCD;
        #1;
        total++;
        if (req_ready !== 2'b10) begin
            bad++;
            $display("FAIL read_ready: got %b want 10", req_ready);
        end
        next_cycle();
        req_valid = 2'b00;
        dpu_rsp_valid = 1'b1;
        dpu_rsp_data = 8'hEE;
        #1;
        total++;
        if (dpu_cmd_valid !== 1'b1 || dpu_cmd_type !== 3'd4 || dpu_cmd_addr !== 24'h00ABCD || owner !== 1'b1) begin
            bad++;
            $display("FAIL read_cmd: got v=%b t=%0d a=%h own=%b want 1 4 00abcd 1",
                     dpu_cmd_valid, dpu_cmd_type, dpu_cmd_addr, owner);
        end
        next_cycle();
        dpu_rsp_valid = 1'b0;
        for (int c = 1; c < 5; c++) begin
            if (rsp_valid != 2'b00) early++;
            next_cycle();
        end
        dpu_rsp_valid = 1'b1;
        dpu_rsp_data = 8'h3C;
        #1;
        if (rsp_valid != 2'b00) early++;
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL read_early_rsp: got %0d early rsp cycles want 0", early);
        end
        next_cycle();
        dpu_rsp_valid = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 2'b10 || rsp_data !== 8'h3C || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL read_rsp: got rv=%b rd=%h err=%b want 10 3c 0", rsp_valid, rsp_data, rsp_err);
        end
        next_cycle();
    endtask

    task automatic test_run_hold();
        int leak = 0;
        req_valid = 2'b11;
        req_type = {CMD_WRITE_BYTE, CMD_RUN};
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL run_ready: got %b want 01", req_ready);
        end
        next_cycle();
        req_valid = 2'b10;
        #1;
        total++;
        if (dpu_cmd_valid !== 1'b1 || dpu_cmd_type !== 3'd2 || owner !== 1'b0) begin
            bad++;
            $display("FAIL run_cmd: got v=%b t=%0d own=%b want 1 2 0", dpu_cmd_valid, dpu_cmd_type, owner);
        end
        next_cycle();
        for (int c = 1; c < 200; c++) begin
            if (req_ready != 2'b00 || rsp_valid != 2'b00) leak++;
            next_cycle();
        end
        dpu_done = 1'b1;
        #1;
        if (req_ready != 2'b00 || rsp_valid != 2'b00) leak++;
        total++;
        if (leak != 0) begin
            bad++;
            $display("FAIL run_hold: got %0d cycles with grant/rsp during run want 0", leak);
        end
        next_cycle();
        dpu_done = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_data !== 8'h00 || req_ready !== 2'b00) begin
            bad++;
            $display("FAIL run_rsp: got rv=%b err=%b rd=%h rdy=%b want 01 0 00 00",
                     rsp_valid, rsp_err, rsp_data, req_ready);
        end
        next_cycle();
        total++;
        if (req_ready !== 2'b10) begin
            bad++;
            $display("FAIL run_next_grant: got %b want 10", req_ready);
        end
        next_cycle();
        req_valid = 2'b00;
        next_cycle();
        total++;
        if (rsp_valid !== 2'b10) begin
            bad++;
            $display("FAIL run_next_rsp: got %b want 10", rsp_valid);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        int got = 0;
        logic got_err = 1'b0;
        logic [7:0] got_data = 8'h00;
        logic [1:0] got_rv = 2'b00;

        t_dpu_cmd_ready = 1'b1;
        t_req_valid = 2'b01;
        req_type[2:0] = CMD_READ_BYTE;
        #1;
        total++;
        if (t_req_ready !== 2'b01) begin
            bad++;
            $display("FAIL to_ready: got %b want 01", t_req_ready);
        end
        next_cycle();
        t_req_valid = 2'b00;
        for (int k = 1; k <= 30; k++) begin
            next_cycle();
            if (t_rsp_valid != 2'b00) begin
                got = k; got_err = t_rsp_err; got_data = t_rsp_data; got_rv = t_rsp_valid;
                break;
            end
        end
        total++;
        if (got != 16 || got_rv !== 2'b01 || got_err !== 1'b1 || got_data !== 8'h00) begin
            bad++;
            $display("FAIL to_expire: got cycle=%0d rv=%b err=%b rd=%h want 16 01 1 00",
                     got, got_rv, got_err, got_data);
        end

        // Completion arriving on the very cycle the timeout fires must win.
        next_cycle();
        t_req_valid = 2'b01;
        #1;
        total++;
        if (t_req_ready !== 2'b01) begin
            bad++;
            $display("FAIL to_race_ready: got %b want 01", t_req_ready);
        end
        next_cycle();
        t_req_valid = 2'b00;
        got = 0;
        dpu_rsp_data = 8'h5A;
        for (int k = 1; k <= 30; k++) begin
            next_cycle();
            dpu_rsp_valid = (k == 15);
            if (t_rsp_valid != 2'b00) begin
                got = k; got_err = t_rsp_err; got_data = t_rsp_data; got_rv = t_rsp_valid;
                break;
            end
        end
        dpu_rsp_valid = 1'b0;
        total++;
        if (got != 16 || got_rv !== 2'b01 || got_err !== 1'b0 || got_data !== 8'h5A) begin
            bad++;
            $display("FAIL to_race: got cycle=%0d rv=%b err=%b rd=%h want 16 01 0 5a",
                     got, got_rv, got_err, got_data);
        end

        next_cycle();
        t_req_valid = 2'b01;
        req_type[2:0] = CMD_WRITE_BYTE;
        #1;
        total++;
        if (t_req_ready !== 2'b01) begin
            bad++;
            $display("FAIL to_next_ready: got %b want 01", t_req_ready);
        end
        next_cycle();
        t_req_valid = 2'b00;
        next_cycle();
        total++;
        if (t_rsp_valid !== 2'b01 || t_rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL to_next_rsp: got rv=%b err=%b want 01 0", t_rsp_valid, t_rsp_err);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_run();
        int stray = 0;
        // Complete a req0 command first so the pointer sits at 1 before reset.
        req_valid = 2'b01;
        req_type = {CMD_RUN, CMD_WRITE_BYTE};
        next_cycle();
        req_valid = 2'b00;
        next_cycle();
        next_cycle();
        req_valid = 2'b10;
        #1;
        total++;
        if (req_ready !== 2'b10) begin
            bad++;
            $display("FAIL rst_pre_ready: got %b want 10", req_ready);
        end
        next_cycle();
        req_valid = 2'b00;
        repeat (5) next_cycle();
        total++;
        if (busy_arb !== 1'b1 || owner !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_busy: got busy=%b own=%b want 1 1", busy_arb, owner);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_data, rsp_err, dpu_cmd_valid, dpu_cmd_type,
             dpu_cmd_addr, dpu_cmd_data, owner, busy_arb} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got rdy=%b rv=%b rd=%h err=%b cv=%b own=%b busy=%b, want all 0",
                     req_ready, rsp_valid, rsp_data, rsp_err, dpu_cmd_valid, owner, busy_arb);
        end
        next_cycle();
        if (rsp_valid != 2'b00) stray++;
        rst_n = 1'b1;
        next_cycle();
        if (rsp_valid != 2'b00 || busy_arb) stray++;
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL rst_mid_no_rsp: got %0d cycles with rsp/busy after reset want 0", stray);
        end
        req_valid = 2'b11;
        req_type = {CMD_WRITE_BYTE, CMD_WRITE_BYTE};
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL rst_first_winner: got %b want 01", req_ready);
        end
        next_cycle();
        req_valid = 2'b00;
        next_cycle();
        total++;
        if (rsp_valid !== 2'b01) begin
            bad++;
            $display("FAIL rst_first_rsp: got %b want 01", rsp_valid);
        end
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_byte();
        test_round_robin();
        test_read_byte();
        test_run_hold();
        test_timeout();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
